// File: rtl/reg_serial_tx.sv
// rtl/reg_serial_tx.sv - parallel-to-serial MSB-first transmitter with frame counter
// Optional even parity bit: define REG_TX_PARITY_EN.
module reg_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic [7:0]       frame_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef REG_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       frame_q, frame_d;
    // Holds load_ready low through reset and until the first edge after release.
    logic             ready_en_q, ready_en_d;
`ifdef REG_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            frame_q    <= '0;
            ready_en_q <= 1'b0;
`ifdef REG_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            ready_en_q <= ready_en_d;
`ifdef REG_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        ready_en_d = 1'b1;
`ifdef REG_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        load_ready = 1'b0;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;

        case (state_q)
            IDLE: begin
                load_ready = ready_en_q;
                if (load_valid && ready_en_q) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef REG_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg_q[WIDTH-1];
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
`ifdef REG_TX_PARITY_EN
                    state_d  = PARITY;
`else
                    ser_last = 1'b1;
                    state_d  = IDLE;
                    frame_d  = frame_q + 8'd1;
`endif
                end
            end
`ifdef REG_TX_PARITY_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_out   = parity_q;
                ser_last  = 1'b1;
                state_d   = IDLE;
                frame_d   = frame_q + 8'd1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_reg_serial_tx.sv
// tb/tb_reg_serial_tx.sv - directed self-checking bench for reg_serial_tx
module tb_reg_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REG_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int FRAME_PERIOD = 10;
`else
    localparam bit PAR = 1'b0;
    localparam int FRAME_PERIOD = 9;
`endif

    reg_serial_tx #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        load_valid = 1'b0;
        data_in    = 8'h00;
        #1;
        check_eq("rst_ready", load_ready, 0);
        check_eq("rst_valid", ser_valid, 0);
        check_eq("rst_out", ser_out, 0);
        check_eq("rst_last", ser_last, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        check_eq("rel_ready_low", load_ready, 0);
        step();
        check_eq("rel_ready_high", load_ready, 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!load_ready && n < 20) begin
            step();
            n++;
        end
        check_eq("ready_timeout", load_ready, 1);
    endtask

    // Called #1 after the acceptance edge; returns #1 after the edge ending the frame.
    task automatic expect_frame(input logic [7:0] w, input bit toggle);
        for (int i = 0; i < 8; i++) begin
            check_eq("bit_valid", ser_valid, 1);
            check_eq("bit_out", ser_out, w[7-i]);
            check_eq("bit_last", ser_last, (i == 7) && !PAR);
            if (toggle) begin
                check_eq("busy_ready", load_ready, 0);
                data_in = (i % 2 == 0) ? 8'h03 : 8'hFF;
            end
            step();
        end
        if (PAR) begin
            check_eq("par_valid", ser_valid, 1);
            check_eq("par_out", ser_out, ^w);
            check_eq("par_last", ser_last, 1);
            step();
        end
    endtask

    task automatic send(input logic [7:0] w);
        data_in    = w;
        load_valid = 1'b1;
        wait_ready();
        step();
        load_valid = 1'b0;
        expect_frame(w, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        data_in    = 8'h00;

        // basic frame
        do_reset();
        send(8'hA5);
        check_eq("basic_idle_valid", ser_valid, 0);
        check_eq("basic_frame_cnt", frame_cnt, 1);

        // back-to-back with load_valid held
        do_reset();
        data_in    = 8'h05;
        load_valid = 1'b1;
        step();
        data_in = 8'h0A;
        expect_frame(8'h05, 1'b0);
        check_eq("b2b_gap_valid", ser_valid, 0);
        check_eq("b2b_gap_ready", load_ready, 1);
        step();
        load_valid = 1'b0;
        expect_frame(8'h0A, 1'b0);
        check_eq("b2b_frame_cnt", frame_cnt, 2);

        // busy: producer keeps offering changing data during the frame
        do_reset();
        data_in    = 8'h5A;
        load_valid = 1'b1;
        step();
        expect_frame(8'h5A, 1'b1);
        load_valid = 1'b0;
        repeat (4) begin
            step();
            check_eq("busy_no_extra", ser_valid, 0);
        end
        check_eq("busy_frame_cnt", frame_cnt, 1);

        // reset mid-frame
        do_reset();
        send(8'h00);
        check_eq("abort_pre_cnt", frame_cnt, 1);
        data_in    = 8'hFF;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (3) step();
        check_eq("abort_pre_valid", ser_valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_out", ser_out, 0);
        check_eq("abort_valid", ser_valid, 0);
        check_eq("abort_last", ser_last, 0);
        check_eq("abort_frame_cnt", frame_cnt, 0);
        check_eq("abort_ready", load_ready, 0);
        step();
        rst_n = 1'b1;
        check_eq("abort_rel_ready_low", load_ready, 0);
        step();
        check_eq("abort_rel_ready", load_ready, 1);
        check_eq("abort_rel_valid", ser_valid, 0);
        check_eq("abort_rel_cnt", frame_cnt, 0);

        // frame counter wrap
        do_reset();
        data_in    = 8'h00;
        load_valid = 1'b1;
        repeat (255 * FRAME_PERIOD) step();
        check_eq("wrap_255", frame_cnt, 255);
        repeat (FRAME_PERIOD) step();
        load_valid = 1'b0;
        check_eq("wrap_0", frame_cnt, 0);
        check_eq("wrap_idle", ser_valid, 0);

`ifdef REG_TX_PARITY_EN
        do_reset();
        send(8'h07);
        send(8'h03);
        check_eq("par_frame_cnt", frame_cnt, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
